// File: rtl/fpu_pkg.sv
// Shared FPU definitions: canonical quiet NaN, rounding-mode encodings and
// the result entry carried from the multiplier issue stage to writeback.
package fpu_pkg;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        DYN = 3'b111
    } rm_e;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        illegal;
    } result_t;

endpackage

// File: rtl/fpu_result_fifo.sv
// Result FIFO between the multiplier and writeback.
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   flush            clears pointers and count at the next edge (beats push/pop)
//   push, push_data  write one result entry
//   pop              remove head entry (ignored when empty)
//   head             entry at the read pointer
//   count            number of stored entries (0..DEPTH)
module fpu_result_fifo
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  result_t                  push_data,
    input  logic                     pop,
    output result_t                  head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);

    result_t           mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW:0]       count_q;
    logic              do_push, do_pop;

    // Push at full is only allowed when the head leaves in the same cycle.
    always_comb begin
        do_pop  = pop && (count_q != '0);
        do_push = push && ((count_q != (PW+1)'(DEPTH)) || do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fpu_mult_issue.sv
// Issue stage for a one-cycle FP multiplier with an in-order result FIFO.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   op_*                     core request (valid/ready, operands, rm, dest tag)
//   frm                      CSR dynamic rounding mode
//   flush                    discard in-flight and buffered ops
//   mult_req/a/b/rm          multiplier request (combinational in accept cycle)
//   mult_out, mult_valid     multiplier result, one cycle after mult_req
//   wb_*                     writeback handshake and head-of-FIFO result
//   busy                     any op in flight or buffered
//   proto_err                sticky: missing or unexpected multiplier result
module fpu_mult_issue
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [2:0]  op_rm,
    input  logic [4:0]  op_rd,
    input  logic [2:0]  frm,
    input  logic        flush,
    output logic        mult_req,
    output logic [31:0] mult_a,
    output logic [31:0] mult_b,
    output logic [2:0]  mult_rm,
    input  logic [31:0] mult_out,
    input  logic        mult_valid,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_illegal,
    output logic        busy,
    output logic        proto_err
);

    localparam int unsigned CW = $clog2(DEPTH);

    logic [CW:0]   count;
    logic [CW+1:0] occupancy;
    logic [2:0]    eff_rm;
    logic          legal, accept;
    logic          push, pop, missing, spurious;
    result_t       push_data, head;

    logic          inflight_v_q;
    logic [4:0]    inflight_rd_q;
    logic          inflight_ill_q;
    logic          proto_err_q;
    // Bit 0 masks the unexpected-result check in the current cycle; set for
    // the two cycles after reset and the cycle after a flush, when a stale
    // result from a dropped op may still arrive.
    logic [1:0]    ign_q;

    always_comb begin
        eff_rm    = (op_rm == DYN) ? frm : op_rm;
        legal     = (eff_rm <= RMM);
        // Reserve a FIFO slot for the in-flight op so its result always fits.
        occupancy = {1'b0, count} + (CW+2)'(inflight_v_q);
        op_ready  = rst && !flush && (occupancy < (CW+2)'(DEPTH));
        accept    = op_valid && op_ready;
        mult_req  = accept && legal;
        mult_a    = op_a;
        mult_b    = op_b;
        mult_rm   = eff_rm;
    end

    always_comb begin
        push      = inflight_v_q && (inflight_ill_q || mult_valid);
        push_data = '{data:    inflight_ill_q ? QNAN : mult_out,
                      rd:      inflight_rd_q,
                      illegal: inflight_ill_q};
        missing   = inflight_v_q && !inflight_ill_q && !mult_valid;
        spurious  = mult_valid && !(inflight_v_q && !inflight_ill_q) && !ign_q[0];
        pop       = wb_valid && wb_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_v_q   <= 1'b0;
            inflight_rd_q  <= '0;
            inflight_ill_q <= 1'b0;
            proto_err_q    <= 1'b0;
            ign_q          <= 2'b11;
        end else begin
            inflight_v_q   <= accept && !flush;
            inflight_rd_q  <= op_rd;
            inflight_ill_q <= !legal;
            proto_err_q    <= proto_err_q || missing || spurious;
            ign_q          <= {1'b0, ign_q[1] || flush};
        end
    end

    fpu_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign wb_valid   = (count != '0);
    assign wb_data    = head.data;
    assign wb_rd      = head.rd;
    assign wb_illegal = head.illegal;
    assign busy       = inflight_v_q || (count != '0);
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_fpu_mult_issue.sv
// Bench for fpu_mult_issue: table-driven single ops, hand-written stall,
// streaming, flush, protocol-error and reset sequences, all checked through
// a scoreboard queue of expected writebacks.
module tb_fpu_mult_issue;
    import fpu_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk, rst;
    logic        op_valid, op_ready;
    logic [31:0] op_a, op_b;
    logic [2:0]  op_rm, frm;
    logic [4:0]  op_rd;
    logic        flush;
    logic        mult_req;
    logic [31:0] mult_a, mult_b;
    logic [2:0]  mult_rm;
    logic [31:0] mult_out;
    logic        mult_valid;
    logic        wb_valid, wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_illegal, busy, proto_err;

    fpu_mult_issue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_rm(op_rm), .op_rd(op_rd), .frm(frm),
        .flush(flush), .mult_req(mult_req), .mult_a(mult_a), .mult_b(mult_b),
        .mult_rm(mult_rm), .mult_out(mult_out), .mult_valid(mult_valid),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_illegal(wb_illegal), .busy(busy), .proto_err(proto_err)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        ill;
        int          cyc;
    } sb_t;

    typedef struct {
        logic [31:0] a, b;
        logic [2:0]  rm, frm;
        logic [4:0]  rd;
        logic [31:0] exp_data;
        logic        exp_ill;
    } vec_t;

    sb_t         sb_q[$];
    vec_t        vecs[8];
    logic [31:0] vals[7];
    int          total = 0, bad = 0, cyc = 0;
    bit          chk_lat = 1'b1;
    bit          last_acc;
    logic [31:0] cur_exp;
    logic        cur_ill;
    logic [2:0]  cur_rm;
    logic        force_mv = 1'b0, drop_mv = 1'b0;
    int          nacc, idx;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Exact multiply for normal operands whose product fits in 24 mantissa bits.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        logic [22:0] m;
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 10'd1;
        end else begin
            m = p[45:23];
        end
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    // Multiplier model: result one cycle after the request.
    initial begin
        mult_valid = 1'b0;
        mult_out   = '0;
    end
    always @(posedge clk) begin
        mult_valid <= (mult_req && !drop_mv) || force_mv;
        mult_out   <= fmul(mult_a, mult_b);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic set_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] rm, input logic [4:0] rd);
        op_a    = a;
        op_b    = b;
        op_rm   = rm;
        op_rd   = rd;
        cur_rm  = (rm == 3'b111) ? frm : rm;
        cur_ill = (cur_rm > 3'b100);
        cur_exp = cur_ill ? 32'h7FC00000 : fmul(a, b);
    endtask

    task automatic gen_op(input int i);
        set_op(vals[i % 7], vals[(i * 3 + 1) % 7],
               ((i % 6) == 5) ? 3'b110 : 3'(i % 6), 5'(i + 16));
    endtask

    // One cycle: called just after a negedge with inputs set, returns at the next negedge.
    task automatic tick();
        sb_t e;
        #1;
        last_acc = op_valid && op_ready;
        chk("mult_req", {31'b0, mult_req}, {31'b0, last_acc && !cur_ill});
        if (last_acc && !cur_ill) begin
            chk("mult_a", mult_a, op_a);
            chk("mult_b", mult_b, op_b);
            chk("mult_rm", 32'(mult_rm), 32'(cur_rm));
        end
        if (wb_valid && wb_ready) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_wb act=%h exp=none", wb_data);
            end else begin
                e = sb_q.pop_front();
                chk("wb_data", wb_data, e.data);
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk("wb_illegal", 32'(wb_illegal), 32'(e.ill));
                if (chk_lat) chk("latency", 32'(cyc - e.cyc), 32'd2);
            end
        end
        if (last_acc) sb_q.push_back('{data: cur_exp, rd: op_rd, ill: cur_ill, cyc: cyc});
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vals = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h3FC00000,
                 32'h40800000, 32'hC0000000, 32'h3E800000};
        //          a             b             rm      frm     rd     data           ill
        vecs[0] = '{32'h40000000, 32'h40400000, 3'b000, 3'b000, 5'd7,  32'h40C00000, 1'b0};
        vecs[1] = '{32'h40000000, 32'h40400000, 3'b111, 3'b101, 5'd3,  32'h7FC00000, 1'b1};
        vecs[2] = '{32'h3FC00000, 32'h40000000, 3'b001, 3'b000, 5'd1,  32'h40400000, 1'b0};
        vecs[3] = '{32'h3F800000, 32'hC0A00000, 3'b111, 3'b100, 5'd31, 32'hC0A00000, 1'b0};
        vecs[4] = '{32'h3F800000, 32'h3F800000, 3'b101, 3'b000, 5'd9,  32'h7FC00000, 1'b1};
        vecs[5] = '{32'h3F800000, 32'h3F800000, 3'b110, 3'b000, 5'd10, 32'h7FC00000, 1'b1};
        vecs[6] = '{32'h3F800000, 32'h3F800000, 3'b111, 3'b111, 5'd11, 32'h7FC00000, 1'b1};
        vecs[7] = '{32'h40800000, 32'h3E800000, 3'b011, 3'b010, 5'd0,  32'h3F800000, 1'b0};

        rst = 1'b0; op_valid = 1'b1; flush = 1'b0; wb_ready = 1'b1; frm = 3'b000;
        set_op(32'h40000000, 32'h40000000, 3'b000, 5'd0);
        #12;
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_mult_req", 32'(mult_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_proto_err", 32'(proto_err), 0);
        op_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_op_ready", 32'(op_ready), 1);

        // Table of isolated ops, wb_ready=1: result exactly two cycles after accept.
        for (int i = 0; i < 8; i++) begin
            frm = vecs[i].frm;
            set_op(vecs[i].a, vecs[i].b, vecs[i].rm, vecs[i].rd);
            cur_exp  = vecs[i].exp_data;
            cur_ill  = vecs[i].exp_ill;
            op_valid = 1'b1;
            tick();
            chk("tbl_accept", 32'(last_acc), 1);
            op_valid = 1'b0;
            tick();
            tick();
            tick();
            chk("tbl_drained", 32'(sb_q.size()), 0);
        end
        frm = 3'b000;

        // Stalled writeback: only DEPTH ops fit, then drain in order.
        wb_ready = 1'b0; chk_lat = 1'b0; nacc = 0; idx = 0;
        gen_op(0);
        op_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (last_acc) begin
                nacc++;
                idx++;
                gen_op(idx);
            end
        end
        chk("stall_accepts", 32'(nacc), 32'(DEPTH));
        chk("stall_op_ready", 32'(op_ready), 0);
        chk("stall_wb_valid", 32'(wb_valid), 1);
        wb_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (idx == 6 && sb_q.size() == 0) break;
            tick();
            if (last_acc) begin
                idx++;
                if (idx == 6) op_valid = 1'b0;
                else gen_op(idx);
            end
        end
        op_valid = 1'b0;
        chk("stall_all_accepted", 32'(idx), 6);
        chk("stall_drained", 32'(sb_q.size()), 0);

        // Back-to-back stream: ready never drops, results on consecutive cycles.
        chk_lat = 1'b1;
        for (int i = 0; i < 8; i++) begin
            gen_op(i + 10);
            op_valid = 1'b1;
            tick();
            chk("b2b_accept", 32'(last_acc), 1);
        end
        op_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("b2b_drained", 32'(sb_q.size()), 0);

        // Flush with two buffered results and one in flight, then a stale result.
        wb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_op(vals[i], vals[i + 1], 3'b000, 5'(i + 4));
            op_valid = 1'b1;
            tick();
        end
        op_valid = 1'b0;
        chk("pre_flush_busy", 32'(busy), 1);
        flush = 1'b1;
        force_mv = 1'b1;
        tick();
        flush = 1'b0;
        force_mv = 1'b0;
        sb_q.delete();
        chk("flush_wb_valid", 32'(wb_valid), 0);
        chk("flush_busy", 32'(busy), 0);
        chk("flush_mult_valid_seen", 32'(mult_valid), 1);
        tick();
        chk("flush_proto_err", 32'(proto_err), 0);
        chk("flush_no_write", 32'(wb_valid), 0);
        wb_ready = 1'b1;
        set_op(32'h40000000, 32'h40400000, 3'b000, 5'd12);
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("post_flush_drained", 32'(sb_q.size()), 0);

        // Unexpected multiplier result while idle sets a sticky error.
        force_mv = 1'b1;
        tick();
        force_mv = 1'b0;
        tick();
        chk("spurious_proto_err", 32'(proto_err), 1);
        tick();
        tick();
        chk("proto_err_sticky", 32'(proto_err), 1);
        chk("spurious_no_write", 32'(wb_valid), 0);

        // Reset mid-stream, then a stale result in the first cycle out of reset.
        for (int i = 0; i < 3; i++) begin
            gen_op(i + 30);
            op_valid = 1'b1;
            tick();
        end
        rst = 1'b0;
        #1;
        chk("midrst_wb_valid", 32'(wb_valid), 0);
        chk("midrst_mult_req", 32'(mult_req), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_proto_err", 32'(proto_err), 0);
        op_valid = 1'b0;
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        force_mv = 1'b1;
        @(negedge clk);
        force_mv = 1'b0;
        chk("postrst_op_ready", 32'(op_ready), 1);
        chk("postrst_mult_valid_seen", 32'(mult_valid), 1);
        @(negedge clk);
        chk("postrst_wb_valid", 32'(wb_valid), 0);
        chk("postrst_busy", 32'(busy), 0);
        chk("postrst_proto_err", 32'(proto_err), 0);

        // Multiplier fails to answer a legal op: error, no FIFO write.
        drop_mv = 1'b1;
        set_op(32'h40000000, 32'h40000000, 3'b000, 5'd5);
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        tick();
        tick();
        drop_mv = 1'b0;
        chk("missing_proto_err", 32'(proto_err), 1);
        chk("missing_no_write", 32'(wb_valid), 0);
        sb_q.delete();

        chk("sb_final", 32'(sb_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
